// File: rtl/spike_pkg.sv
// spike_pkg
// Shared definitions for the spike event packer and its event FIFO:
// default parameter values, the refractory FSM state encoding and the
// saturation limits of the status counters.
package spike_pkg;

  localparam int unsigned TS_W_DEF    = 16;
  localparam int unsigned DEPTH_DEF   = 8;
  localparam int unsigned REFRACT_DEF = 16;
  localparam int unsigned CNT_W_DEF   = 16;

  // drop_count is always 8 bits wide and holds at this value.
  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REFR = 1'b1
  } spk_state_e;

endpackage

// File: rtl/spike_evt_fifo.sv
// spike_evt_fifo
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// dout whenever empty is low; dout reads 0 while empty.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - synchronous flush
//   push, din - write request and data; accepted when not full, or when
//               full and a pop happens on the same edge
//   pop       - advance the head; ignored while empty
//   dout      - head entry
//   full, empty
module spike_evt_fifo
  import spike_pkg::*;
#(
  parameter int unsigned W     = TS_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit separates full (MSBs differ) from empty (equal).
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clear) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spike_event_packer.sv
// spike_event_packer
// Turns the detector's per-cycle spike level into timestamped events,
// suppresses re-triggers inside a refractory window, queues events in a
// FWFT FIFO and streams them out over valid/ready.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   en           - sample enable: gates timestamp, edge detect, refractory count
//   clear        - synchronous soft clear, same effect as rst
//   spike_in     - detector level
//   evt_valid    - head event available
//   evt_ready    - consumer takes the head event
//   evt_ts       - head event timestamp (0 when empty)
//   spike_count  - accepted events, saturating
//   drop_count   - events lost to a full FIFO, saturating at 255
//   overflow     - sticky drop flag
//   dbg_state    - refractory FSM state
// Stream handshake: an event transfers on every rising edge where
// evt_valid && evt_ready; evt_ts holds steady while evt_valid && !evt_ready,
// and evt_ready has no effect while evt_valid is low.
module spike_event_packer
  import spike_pkg::*;
#(
  parameter int unsigned TS_W    = TS_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned REFRACT = REFRACT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             spike_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [TS_W-1:0]  evt_ts,
  output logic [CNT_W-1:0] spike_count,
  output logic [7:0]       drop_count,
  output logic             overflow,
  output spk_state_e       dbg_state
);

  localparam int unsigned RC_W = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam logic [RC_W-1:0] RLOAD = RC_W'((REFRACT > 0) ? REFRACT - 1 : 0);

  spk_state_e       state_q, state_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic             spike_prev_q;
  logic [CNT_W-1:0] spike_cnt_q, spike_cnt_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             ovf_q, ovf_d;

  logic edge_det;
  logic window_open;
  logic accept;
  logic pop_fire;
  logic drop;
  logic fifo_full;
  logic fifo_empty;

  assign edge_det = en && spike_in && !spike_prev_q;
  // The last refractory cycle (count at zero) already accepts a new edge,
  // so the next event can land exactly REFRACT enabled cycles after the
  // previous one.
  assign window_open = (state_q == ST_IDLE) || (rcnt_q == '0);
  assign accept      = edge_det && window_open;
  assign pop_fire    = !fifo_empty && evt_ready;
  assign drop        = accept && fifo_full && !pop_fire;

  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    ts_d        = ts_q;
    spike_cnt_d = spike_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    ovf_d       = ovf_q;

    if (en) ts_d = ts_q + 1'b1;

    if (accept) begin
      if (REFRACT > 0) begin
        state_d = ST_REFR;
        rcnt_d  = RLOAD;
      end
    end else if (state_q == ST_REFR && en) begin
      if (rcnt_q == '0) state_d = ST_IDLE;
      else              rcnt_d  = rcnt_q - 1'b1;
    end

    if (accept && spike_cnt_q != '1) spike_cnt_d = spike_cnt_q + 1'b1;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rcnt_q       <= '0;
      ts_q         <= '0;
      spike_prev_q <= 1'b0;
      spike_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      ovf_q        <= 1'b0;
    end else if (clear) begin
      state_q      <= ST_IDLE;
      rcnt_q       <= '0;
      ts_q         <= '0;
      spike_prev_q <= 1'b0;
      spike_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      ts_q         <= ts_d;
      // Sampled regardless of en: a level that rises while disabled is
      // never seen as an edge later.
      spike_prev_q <= spike_in;
      spike_cnt_q  <= spike_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  spike_evt_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (accept),
    .pop   (evt_ready),
    .din   (ts_q),
    .dout  (evt_ts),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid   = !fifo_empty;
  assign spike_count = spike_cnt_q;
  assign drop_count  = drop_cnt_q;
  assign overflow    = ovf_q;
  assign dbg_state   = state_q;

endmodule
